modulo_unit: RTL and testbench

Sequential unsigned modulo engine for the GCD datapath: computes `op_a_i mod op_b_i` by restoring division, one quotient bit per clock. It is the responder side of the `modulo_start_i` / `modulo_ready_o` handshake that the GCD controller and datapath issue. It sits inside the ALU in place of a combinational `%`, so the write-back of `erg_modulo` happens only after `modulo_ready_o`.

---
 rtl/gcd_pkg.sv | 18 +
 rtl/modulo_unit.sv | 78 +++++++
 tb/tb_modulo_unit.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// gcd_pkg: shared types and sizing for the GCD datapath and its modulo engine.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } mod_state_t;

    localparam int GCD_WIDTH = 16;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int GCD_CNT_W = cnt_width(GCD_WIDTH);

endpackage

// File: rtl/modulo_unit.sv
// modulo_unit: unsigned op_a mod op_b by restoring division, one dividend bit per clock.
module modulo_unit
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic             modulo_start_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic [WIDTH-1:0] res_o,
    output logic             modulo_ready_o,
    output logic             div_by_zero_o,
    output logic             busy_o
);

    localparam int CW = cnt_width(WIDTH);

    mod_state_t       r_state, w_state_nxt;
    logic [WIDTH-1:0] r_a, r_b, r_rem, w_rem_nxt;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   w_t;
    logic             w_ge;
    logic             w_accept;

    // The remainder is always below r_b, so the WIDTH-bit subtraction cannot lose a carry.
    assign w_t       = {r_rem, r_a[r_cnt]};
    assign w_ge      = w_t >= {1'b0, r_b};
    assign w_rem_nxt = w_ge ? w_t[WIDTH-1:0] - r_b : w_t[WIDTH-1:0];
    assign w_accept  = (r_state == IDLE) && modulo_start_i;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = modulo_start_i ? ((op_b_i == '0) ? DONE : CALC) : IDLE;
            CALC:    w_state_nxt = (r_cnt == '0) ? DONE : CALC;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state        <= IDLE;
            r_a            <= '0;
            r_b            <= '0;
            r_rem          <= '0;
            r_cnt          <= '0;
            res_o          <= '0;
            modulo_ready_o <= 1'b0;
            div_by_zero_o  <= 1'b0;
            busy_o         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            modulo_ready_o <= w_state_nxt == DONE;
            busy_o         <= w_state_nxt != IDLE;
            if (w_accept) begin
                r_a   <= op_a_i;
                r_b   <= op_b_i;
                r_rem <= '0;
                r_cnt <= CW'(WIDTH - 1);
                if (op_b_i == '0) begin
                    res_o         <= op_a_i;
                    div_by_zero_o <= 1'b1;
                end
            end else if (r_state == CALC) begin
                r_rem <= w_rem_nxt;
                if (r_cnt == '0) begin
                    res_o         <= w_rem_nxt;
                    div_by_zero_o <= 1'b0;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_modulo_unit.sv
// tb_modulo_unit: scoreboard bench; a cycle model predicts acceptance, result and ready edge.
module tb_modulo_unit;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] res;
        logic         dbz;
        int           due;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    logic         modulo_start_i = 1'b0;
    logic [W-1:0] op_a_i = '0;
    logic [W-1:0] op_b_i = '0;
    logic [W-1:0] res_o;
    logic         modulo_ready_o;
    logic         div_by_zero_o;
    logic         busy_o;

    exp_t         q[$];
    int           m_busy = 0;
    int           edge_n = 0;
    logic [W-1:0] last_res = '0;
    logic         last_dbz = 1'b0;
    int           n_chk = 0;
    int           n_pass = 0;

    modulo_unit #(.WIDTH(W)) dut (
        .clk            (clk),
        .rst_ni         (rst_ni),
        .modulo_start_i (modulo_start_i),
        .op_a_i         (op_a_i),
        .op_b_i         (op_b_i),
        .res_o          (res_o),
        .modulo_ready_o (modulo_ready_o),
        .div_by_zero_o  (div_by_zero_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    endtask

    // Reference model: accepts only when idle, result is a % b (or a when b is 0).
    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            q.delete();
            m_busy <= 0;
        end else begin
            edge_n <= edge_n + 1;
            if (m_busy > 0) begin
                m_busy <= m_busy - 1;
            end else if (modulo_start_i) begin
                q.push_back('{res: (op_b_i == '0) ? op_a_i : op_a_i % op_b_i,
                              dbz: op_b_i == '0,
                              due: edge_n + 1 + ((op_b_i == '0) ? 0 : W)});
                m_busy <= (op_b_i == '0) ? 1 : W + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_ni) begin
            last_res <= '0;
            last_dbz <= 1'b0;
        end else begin
            if (q.size() > 0 && q[0].due == edge_n) begin
                chk("ready", 32'(modulo_ready_o), 32'd1);
                chk("res", 32'(res_o), 32'(q[0].res));
                chk("dbz", 32'(div_by_zero_o), 32'(q[0].dbz));
                last_res <= q[0].res;
                last_dbz <= q[0].dbz;
                void'(q.pop_front());
            end else begin
                chk("ready_low", 32'(modulo_ready_o), 32'd0);
                chk("res_hold", 32'(res_o), 32'(last_res));
                chk("dbz_hold", 32'(div_by_zero_o), 32'(last_dbz));
            end
            chk("busy", 32'(busy_o), 32'(m_busy > 0));
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((m_busy != 0 || q.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(n < 60), 32'd1);
    endtask

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        modulo_start_i = 1'b1;
        op_a_i = a;
        op_b_i = b;
        @(negedge clk);
        modulo_start_i = 1'b0;
        op_a_i = $urandom();
        op_b_i = $urandom();
        wait_idle();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_res", 32'(res_o), 32'd0);
        chk("rst_ready", 32'(modulo_ready_o), 32'd0);
        chk("rst_dbz", 32'(div_by_zero_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        rst_ni = 1'b1;

        run(16'd48, 16'd18);
        run(16'd5, 16'd9);
        run(16'hFFFF, 16'd1);
        run(16'd7, 16'd0);
        run(16'd48, 16'd18);

        // Start held high; operands change during CALC and must be ignored.
        @(negedge clk);
        modulo_start_i = 1'b1;
        op_a_i = 16'd100;
        op_b_i = 16'd7;
        @(negedge clk);
        op_a_i = 16'd3;
        op_b_i = 16'd2;
        repeat (19) @(negedge clk);
        modulo_start_i = 1'b0;
        wait_idle();

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        modulo_start_i = 1'b1;
        op_a_i = 16'd1234;
        op_b_i = 16'd77;
        @(negedge clk);
        modulo_start_i = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_res", 32'(res_o), 32'd0);
        chk("arst_ready", 32'(modulo_ready_o), 32'd0);
        chk("arst_dbz", 32'(div_by_zero_o), 32'd0);
        chk("arst_busy", 32'(busy_o), 32'd0);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        run(16'd18, 16'd48);

        for (int i = 0; i < 25; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom());
            b = (i % 3 == 0) ? W'($urandom_range(1, 15)) : W'($urandom_range(1, 65535));
            run(a, b);
        end
        run(16'd0, 16'd0);
        run(16'hFFFF, 16'hFFFF);
        run(16'hFFFE, 16'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
